mp3_song_player: RTL and testbench
==================================

// Module: mp3_song_player
// PURPOSE
//  Consumer side of the song-select interface: takes the 2-bit song select from the
//  prev/next switch logic and plays the chosen song. Walks that song's note table in an
//  external synchronous ROM, times each note in beats, and drives the tone generator
//  with a note code and enable. A change of select restarts playback at note 0 of the
//  new song.
// PARAMETERS
//  SONG_W   2           song select width (4 songs)
//  LEN_W    6           note index width (max 64 ROM words per song)
//  NOTE_W   5           note code width (0 = rest)
//  DUR_W    3           duration field width; a note lasts dur+1 beats
//  TICK_DIV 25_000_000  clk cycles per beat
//  GAP      100_000     silent clk cycles between consecutive notes
// PORTS
//  clk        in   1                clock
//  rst        in   1                reset, asynchronous, active-high
//  select     in   SONG_W           requested song
//  play       in   1                1 = play/resume, 0 = pause
//  rom_addr   out  SONG_W+LEN_W     {song_reg, note_idx}, combinational from regs
//  rom_data   in   1+DUR_W+NOTE_W   {end, dur, note}; valid 1 clk after rom_addr
//  note       out  NOTE_W           current note code to tone generator
//  note_valid out  1                tone enable
//  song_idx   out  SONG_W           song currently playing (song_reg)
//  note_idx   out  LEN_W            index of current ROM word
// BEHAVIOUR
//  Reset (async, any state): IDLE; song_reg=0, note_idx=0, note=0, note_valid=0,
//   beat_cnt=0, beats_left=0, gap_cnt=0.
//  States:
//   IDLE : note_valid=0. play=1 -> FETCH (song_reg<=select, note_idx<=0).
//   FETCH: one cycle; ROM registers rom_addr. -> LATCH.
//   LATCH: sample rom_data.
//          end=0 -> note<=data.note, beats_left<=dur+1, beat_cnt<=0, -> PLAY.
//          end=1 with note_idx!=0 -> note_idx<=0, -> FETCH (loop song).
//          end=1 with note_idx==0 (empty song) -> IDLE.
//   PLAY : note_valid=1 while play=1 and note!=0 (rests are silent).
//          beat_cnt counts 0..TICK_DIV-1; at wrap beats_left--.
//          After last beat -> GAP.
//   GAP  : note_valid=0 for GAP cycles; then note_idx+1 (wraps 2^LEN_W-1 -> 0), -> FETCH.
//  Latency: FETCH entry to note_valid=1 is 2 clk (FETCH, LATCH; PLAY asserts).
//   A note occupies exactly (dur+1)*TICK_DIV PLAY cycles, then GAP cycles.
//  Pause:
//   play=0 in PLAY/GAP freezes beat_cnt, beats_left and gap_cnt, and forces
//   note_valid=0; play=1 resumes exactly where frozen.
//   play=0 in FETCH/LATCH completes the fetch, then freezes in PLAY.
//   play=0 in IDLE stays IDLE.
//  Song change: select!=song_reg, checked every cycle in FETCH/LATCH/PLAY/GAP
//   (paused or not).
//   -> next cycle: song_reg<=select, note_idx<=0, counters cleared, note_valid=0,
//      state FETCH.
//   Song change has priority over every other transition in the same cycle.
//   LATCH data from the old address is discarded.
//  Width rules: dur+1 computed at DUR_W+1 bits (dur=7 -> 8 beats);
//   beat_cnt >= clog2(TICK_DIV) bits.
//  select is assumed already synchronous to clk (driven by the switch logic).
// TESTING (TICK_DIV=4, GAP=2; ROM song0 = {n3,d0},{n5,d1},{end}; song1 = {end} at 0)
//  1. rst, play=1, select=0 -> FETCH, LATCH; note=3, note_valid=1 for 4 clk, 0 for 2 clk;
//     note=5 valid 8 clk; gap; end -> loops, note=3 again.
//  2. Pulse rst mid-PLAY -> all outputs 0 and IDLE on same edge, with no clk needed.
//  3. play=0 at PLAY cycle 2 of note 3 for 10 clk -> note_valid=0, counters held;
//     after resume, exactly 2 more valid cycles follow.
//  4. select 0->2 during PLAY -> next clk note_valid=0, song_idx=2, rom_addr={2,0};
//     new note valid 2 clk later.
//  5. select=1 (empty song) -> FETCH, LATCH, IDLE; note_valid never asserts.
//  6. Song with rest (note=0, d2) -> 12 PLAY cycles with note_valid=0; note_idx still advances.

Source files
------------

// File: rtl/mp3_song_player.sv
// Song player: walks the selected song's note table in an external synchronous ROM,
// times each note in beats and drives a tone generator with note code and enable.
module mp3_song_player #(
  parameter int SONG_W   = 2,
  parameter int LEN_W    = 6,
  parameter int NOTE_W   = 5,
  parameter int DUR_W    = 3,
  parameter int TICK_DIV = 25_000_000,
  parameter int GAP      = 100_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SONG_W-1:0]         select,
  input  logic                      play,
  output logic [SONG_W+LEN_W-1:0]   rom_addr,
  input  logic [DUR_W+NOTE_W:0]     rom_data,
  output logic [NOTE_W-1:0]         note,
  output logic                      note_valid,
  output logic [SONG_W-1:0]         song_idx,
  output logic [LEN_W-1:0]          note_idx
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_PLAY, S_GAP} state_t;

  state_t              state_reg, state_next;
  logic [SONG_W-1:0]   song_reg, song_next;
  logic [LEN_W-1:0]    note_idx_reg, note_idx_next;
  logic [NOTE_W-1:0]   note_reg, note_next;
  logic [DUR_W:0]      beats_left_reg, beats_left_next;
  logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;

  logic                rom_end;
  logic [DUR_W-1:0]    rom_dur;
  logic [NOTE_W-1:0]   rom_note;
  logic                song_change;

  assign {rom_end, rom_dur, rom_note} = rom_data;
  assign song_change = (state_reg != S_IDLE) && (select != song_reg);

  always_comb begin
    state_next      = state_reg;
    song_next       = song_reg;
    note_idx_next   = note_idx_reg;
    note_next       = note_reg;
    beats_left_next = beats_left_reg;
    beat_cnt_next   = beat_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (play) begin
          state_next    = S_FETCH;
          song_next     = select;
          note_idx_next = '0;
        end
      end
      S_FETCH: state_next = S_LATCH;
      S_LATCH: begin
        if (!rom_end) begin
          note_next       = rom_note;
          beats_left_next = (DUR_W+1)'(rom_dur) + (DUR_W+1)'(1);
          beat_cnt_next   = '0;
          state_next      = S_PLAY;
        end else if (note_idx_reg != '0) begin
          note_idx_next = '0;
          state_next    = S_FETCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_PLAY: begin
        // Pause simply holds every counter in place.
        if (play) begin
          if (beat_cnt_reg == CNT_W'(TICK_DIV - 1)) begin
            beat_cnt_next = '0;
            if (beats_left_reg <= (DUR_W+1)'(1)) begin
              beats_left_next = '0;
              gap_cnt_next    = '0;
              state_next      = S_GAP;
            end else begin
              beats_left_next = beats_left_reg - (DUR_W+1)'(1);
            end
          end else begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (play) begin
          if (gap_cnt_reg == GAP_W'(GAP - 1)) begin
            gap_cnt_next  = '0;
            note_idx_next = note_idx_reg + LEN_W'(1);
            state_next    = S_FETCH;
          end else begin
            gap_cnt_next = gap_cnt_reg + GAP_W'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A new selection overrides whatever else this cycle would have done.
    if (song_change) begin
      state_next      = S_FETCH;
      song_next       = select;
      note_idx_next   = '0;
      beat_cnt_next   = '0;
      beats_left_next = '0;
      gap_cnt_next    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      song_reg       <= '0;
      note_idx_reg   <= '0;
      note_reg       <= '0;
      beats_left_reg <= '0;
      beat_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      song_reg       <= song_next;
      note_idx_reg   <= note_idx_next;
      note_reg       <= note_next;
      beats_left_reg <= beats_left_next;
      beat_cnt_reg   <= beat_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
    end
  end

  // Rests (note code 0) play for their full length but keep the tone off.
  assign note_valid = (state_reg == S_PLAY) && play && (note_reg != '0);
  assign note       = note_reg;
  assign song_idx   = song_reg;
  assign note_idx   = note_idx_reg;
  assign rom_addr   = {song_reg, note_idx_reg};

endmodule

// File: tb/tb_mp3_song_player.sv
// Directed bench for mp3_song_player with a small note-table ROM; tone bursts are
// scored against a queue of expected {note, length} entries.
module tb_mp3_song_player;

  localparam int SONG_W = 2;
  localparam int LEN_W  = 6;
  localparam int NOTE_W = 5;
  localparam int DUR_W  = 3;

  logic                    clk;
  logic                    rst;
  logic [SONG_W-1:0]       select;
  logic                    play;
  logic [SONG_W+LEN_W-1:0] rom_addr;
  logic [DUR_W+NOTE_W:0]   rom_data;
  logic [NOTE_W-1:0]       note;
  logic                    note_valid;
  logic [SONG_W-1:0]       song_idx;
  logic [LEN_W-1:0]        note_idx;

  logic [DUR_W+NOTE_W:0]   rom [0:255];

  typedef struct {
    logic [NOTE_W-1:0] note;
    int                len;
  } exp_t;

  exp_t              sb_q[$];
  int                checks;
  int                errors;
  int                run_len;
  logic [NOTE_W-1:0] run_note;

  mp3_song_player #(
    .SONG_W(SONG_W), .LEN_W(LEN_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W),
    .TICK_DIV(4), .GAP(2)
  ) dut (
    .clk(clk), .rst(rst), .select(select), .play(play),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .note(note), .note_valid(note_valid),
    .song_idx(song_idx), .note_idx(note_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [NOTE_W-1:0] n, input int len);
    exp_t e;
    e.note = n;
    e.len  = len;
    sb_q.push_back(e);
  endtask

  // Accumulates a tone burst; when it ends, pops the expected burst and compares.
  task automatic sample();
    exp_t e;
    if (note_valid === 1'b1) begin
      if (run_len == 0) run_note = note;
      run_len++;
    end else if (run_len > 0) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_burst", run_len, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_note", run_note, e.note);
        check("sb_len", run_len, e.len);
        $display("burst note=%0d len=%0d (expected note=%0d len=%0d)",
                 run_note, run_len, e.note, e.len);
      end
      run_len = 0;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick(1);
    check(tag, sb_q.size(), 0);
  endtask

  // Leaves time at P0+1 with play=1: FETCH at P1, LATCH at P2, PLAY at P3.
  task automatic restart(input logic [SONG_W-1:0] sel);
    rst    = 1'b1;
    play   = 1'b0;
    select = sel;
    tick(2);
    rst  = 1'b0;
    play = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    run_len  = 0;
    run_note = '0;
    rst      = 1'b1;
    play     = 1'b0;
    select   = '0;
    for (int a = 0; a < 256; a++) rom[a] = 9'h100;
    rom[0]   = {1'b0, 3'd0, 5'd3};
    rom[1]   = {1'b0, 3'd1, 5'd5};
    rom[128] = {1'b0, 3'd0, 5'd7};
    rom[192] = {1'b0, 3'd2, 5'd0};
    rom[193] = {1'b0, 3'd0, 5'd9};

    #1;
    check("rst_note_valid", note_valid, 0);
    check("rst_note", note, 0);
    check("rst_song_idx", song_idx, 0);
    check("rst_note_idx", note_idx, 0);
    check("rst_rom_addr", rom_addr, 0);

    // 1: song 0 plays 3 (4 clk), 5 (8 clk), then loops back to 3
    restart(2'd0);
    push(5'd3, 4); push(5'd5, 8); push(5'd3, 4);
    tick(1);
    check("t1_fetch_valid", note_valid, 0);
    check("t1_fetch_addr", rom_addr, 0);
    tick(2);
    check("t1_play_valid", note_valid, 1);
    check("t1_play_note", note, 3);
    wait_drain("t1_drain", 60);
    $display("test1 song0 loop done");

    // 2: asynchronous reset in the middle of a note
    restart(2'd0);
    push(5'd3, 2);
    tick(3);
    check("t2_play_valid", note_valid, 1);
    tick(1);
    @(negedge clk);
    sample();
    #1;
    rst = 1'b1;
    #1;
    check("t2_async_valid", note_valid, 0);
    check("t2_async_note", note, 0);
    check("t2_async_song", song_idx, 0);
    check("t2_async_idx", note_idx, 0);
    check("t2_async_addr", rom_addr, 0);
    @(posedge clk);
    #1;
    tick(1);
    play = 1'b0;
    rst  = 1'b0;
    tick(3);
    check("t2_idle_valid", note_valid, 0);
    wait_drain("t2_drain", 5);
    $display("test2 async reset done");

    // 3: pause after two beats of note 3, resume for the remaining two
    restart(2'd0);
    push(5'd3, 2); push(5'd3, 2); push(5'd5, 8);
    tick(3);
    check("t3_play_valid", note_valid, 1);
    tick(2);
    play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t3_pause_valid", note_valid, 0);
    end
    check("t3_pause_note", note, 3);
    check("t3_pause_idx", note_idx, 0);
    play = 1'b1;
    wait_drain("t3_drain", 60);
    $display("test3 pause/resume done");

    // 4: switch to song 2 mid-note
    restart(2'd0);
    push(5'd3, 2); push(5'd7, 4);
    tick(3);
    check("t4_play_valid", note_valid, 1);
    tick(1);
    select = 2'd2;
    tick(1);
    check("t4_chg_valid", note_valid, 0);
    check("t4_chg_song", song_idx, 2);
    check("t4_chg_addr", rom_addr, 128);
    check("t4_chg_idx", note_idx, 0);
    tick(2);
    check("t4_new_valid", note_valid, 1);
    check("t4_new_note", note, 7);
    wait_drain("t4_drain", 30);
    $display("test4 song change done");

    // 5: empty song never produces a tone
    restart(2'd1);
    tick(1);
    check("t5_addr", rom_addr, 64);
    check("t5_song", song_idx, 1);
    tick(2);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("t5_valid", note_valid, 0);
    end
    $display("test5 empty song done");

    // 6: song 3 starts with a 3-beat rest, then note 9
    restart(2'd3);
    push(5'd9, 4);
    tick(3);
    check("t6_rest_note", note, 0);
    check("t6_rest_valid", note_valid, 0);
    for (int i = 0; i < 11; i++) begin
      tick(1);
      check("t6_rest_hold", note_valid, 0);
    end
    tick(3);
    check("t6_next_idx", note_idx, 1);
    check("t6_next_addr", rom_addr, 193);
    wait_drain("t6_drain", 30);
    $display("test6 rest song done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
